// File: rtl/pair_exit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pair_exit_arbiter
// Description : Round-robin drain of NUM_SRC pair-exit FIFOs onto a single
//               host read channel. Each rising edge of host_req pops one
//               entry from the next non-empty FIFO and presents it with its
//               source index; an all-empty request returns a zero word
//               flagged empty. Also reports aggregate FIFO occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module pair_exit_arbiter #(
    parameter int NUM_SRC = 4,    // number of exit FIFOs (2..16)
    parameter int SRC_W   = 2,    // ceil(log2(NUM_SRC))
    parameter int DATA_W  = 192,  // one particle pair
    parameter int CNT_W   = 8,    // width of each FIFO data_count
    parameter int RD_LAT  = 1     // FIFO rd_en to valid dout (1..3)
) (
    input  logic                      clk,
    input  logic                      reset,       // asynchronous, active-low
    input  logic [NUM_SRC*CNT_W-1:0]  fifo_count,
    input  logic [NUM_SRC*DATA_W-1:0] fifo_dout,
    output logic [NUM_SRC-1:0]        fifo_rd_en,
    input  logic                      host_req,
    output logic [DATA_W-1:0]         host_data,
    output logic [SRC_W-1:0]          host_src,
    output logic                      host_valid,
    output logic                      host_empty,
    output logic                      busy,
    output logic [31:0]               total_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [SRC_W:0]   c_num_src  = (SRC_W+1)'(NUM_SRC);
    localparam logic [SRC_W-1:0] c_last_src = SRC_W'(NUM_SRC - 1);
    localparam logic [1:0]       c_lat_init = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POP     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [SRC_W-1:0]    rr_ptr_q,     rr_ptr_d;
    logic [SRC_W-1:0]    grant_q,      grant_d;
    logic [1:0]          lat_cnt_q,    lat_cnt_d;
    logic                req_pend_q,   req_pend_d;
    logic                prev_req_q,   prev_req_d;
    logic [NUM_SRC-1:0]  rd_en_q,      rd_en_d;
    logic [DATA_W-1:0]   host_data_q,  host_data_d;
    logic [SRC_W-1:0]    host_src_q,   host_src_d;
    logic                host_valid_q, host_valid_d;
    logic                host_empty_q, host_empty_d;
    logic                busy_q,       busy_d;
    logic [31:0]         total_q,      total_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_edge;
    logic [NUM_SRC-1:0]  w_cnt_nz;
    logic                w_found;
    logic [SRC_W-1:0]    w_grant_sel;

    assign w_edge = host_req & ~prev_req_q;

    // One non-empty flag per FIFO
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt_nz
            assign w_cnt_nz[gi] = |fifo_count[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Round-robin search: first non-empty FIFO at or after rr_ptr, wrapping
    always_comb begin
        logic [SRC_W:0] idx;
        w_found     = 1'b0;
        w_grant_sel = '0;
        idx         = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (idx >= c_num_src) begin
                idx = idx - c_num_src;
            end
            if (!w_found && w_cnt_nz[idx[SRC_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_sel = idx[SRC_W-1:0];
            end
        end
    end

    // Aggregate occupancy; the maximum sum always fits in 32 bits
    always_comb begin
        total_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            total_d = total_d + 32'(fifo_count[i*CNT_W +: CNT_W]);
        end
    end

    // FSM next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        lat_cnt_d    = lat_cnt_q;
        req_pend_d   = req_pend_q;
        prev_req_d   = host_req;
        host_data_d  = host_data_q;
        host_src_d   = host_src_q;
        host_valid_d = host_valid_q;
        host_empty_d = host_empty_q;

        case (state_q)
            ST_IDLE: begin
                if (req_pend_q) begin
                    if (w_found) begin
                        grant_d      = w_grant_sel;
                        host_valid_d = 1'b0;
                        state_d      = ST_POP;
                    end else begin
                        // Nothing to drain: answer with an empty response and
                        // leave the round-robin pointer where it was.
                        host_data_d  = '0;
                        host_valid_d = 1'b0;
                        host_empty_d = 1'b1;
                        req_pend_d   = 1'b0;
                    end
                end else if (w_edge) begin
                    req_pend_d = 1'b1;
                end
            end
            ST_POP: begin
                lat_cnt_d = c_lat_init;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d = ST_PRESENT;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            ST_PRESENT: begin
                host_data_d  = fifo_dout[grant_q*DATA_W +: DATA_W];
                host_src_d   = grant_q;
                host_valid_d = 1'b1;
                host_empty_d = 1'b0;
                req_pend_d   = 1'b0;
                rr_ptr_d     = (grant_q == c_last_src) ? '0 : grant_q + 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The pop strobe is registered so it is high exactly while in POP
        rd_en_d = '0;
        if (state_d == ST_POP) begin
            rd_en_d[grant_d] = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset also kills an in-flight pop strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            lat_cnt_q    <= '0;
            req_pend_q   <= 1'b0;
            prev_req_q   <= 1'b1;   // a level already high at release is not a request
            rd_en_q      <= '0;
            host_data_q  <= '0;
            host_src_q   <= '0;
            host_valid_q <= 1'b0;
            host_empty_q <= 1'b1;
            busy_q       <= 1'b0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            lat_cnt_q    <= lat_cnt_d;
            req_pend_q   <= req_pend_d;
            prev_req_q   <= prev_req_d;
            rd_en_q      <= rd_en_d;
            host_data_q  <= host_data_d;
            host_src_q   <= host_src_d;
            host_valid_q <= host_valid_d;
            host_empty_q <= host_empty_d;
            busy_q       <= busy_d;
            total_q      <= total_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign fifo_rd_en  = rd_en_q;
    assign host_data   = host_data_q;
    assign host_src    = host_src_q;
    assign host_valid  = host_valid_q;
    assign host_empty  = host_empty_q;
    assign busy        = busy_q;
    assign total_count = total_q;

endmodule
`default_nettype wire

// File: tb/tb_pair_exit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pair_exit_arbiter
// Description : Scoreboard bench for pair_exit_arbiter. Stimulus pushes the
//               expected pop strobes and results; a monitor pops and compares
//               whenever the DUT strobes a FIFO or raises host_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pair_exit_arbiter;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;
    localparam int DATA_W  = 192;
    localparam int CNT_W   = 8;
    localparam int RD_LAT  = 1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_SRC*CNT_W-1:0]  fifo_count;
    logic [NUM_SRC*DATA_W-1:0] fifo_dout;
    logic [NUM_SRC-1:0]        fifo_rd_en;
    logic                      host_req;
    logic [DATA_W-1:0]         host_data;
    logic [SRC_W-1:0]          host_src;
    logic                      host_valid;
    logic                      host_empty;
    logic                      busy;
    logic [31:0]               total_count;

    pair_exit_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_count  (fifo_count),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .host_req    (host_req),
        .host_data   (host_data),
        .host_src    (host_src),
        .host_valid  (host_valid),
        .host_empty  (host_empty),
        .busy        (busy),
        .total_count (total_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  src;
        int                cyc;
    } res_t;

    typedef struct {
        logic [NUM_SRC-1:0] en;
        int                 cyc;
    } rd_t;

    res_t res_q[$];
    rd_t  rd_q[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Each FIFO i presents a constant byte pattern 0xA4+i repeated
    function automatic logic [DATA_W-1:0] pat(input int s);
        logic [7:0] b;
        b = 8'(8'hA4 + s);
        return {24{b}};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle counter, advanced on every active edge
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compare every pop strobe and every fresh result
    initial begin
        logic prev_valid;
        rd_t  e;
        res_t r;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_rd_en != '0) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_en_unexpected: got %b expected none", fifo_rd_en);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_en", fifo_rd_en, e.en);
                    chk("rd_en_cycle", cyc, e.cyc);
                end
            end
            if (host_valid && !prev_valid) begin
                if (res_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL result_unexpected: got src %0d expected none", host_src);
                end else begin
                    r = res_q.pop_front();
                    chk("host_data", host_data, r.data);
                    chk("host_src", host_src, r.src);
                    chk("host_empty_on_valid", host_empty, 1'b0);
                    chk("result_cycle", cyc, r.cyc);
                end
            end
            prev_valid = host_valid;
        end
    end

    // Raise one request at a negedge; en==0 means an empty response is due
    task automatic issue(input logic [NUM_SRC-1:0] en, input int src);
        rd_t  e;
        res_t r;
        host_req = 1'b1;
        if (en != '0) begin
            e.en   = en;
            e.cyc  = cyc + 2;
            r.data = pat(src);
            r.src  = SRC_W'(src);
            r.cyc  = cyc + 4 + RD_LAT;
            rd_q.push_back(e);
            res_q.push_back(r);
        end
        @(negedge clk);
        host_req = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (res_q.size() == 0 && rd_q.size() == 0) break;
            @(negedge clk);
        end
        n_checks++;
        if (res_q.size() != 0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d results %0d strobes pending expected 0",
                     res_q.size(), rd_q.size());
            res_q.delete();
            rd_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        host_req = 1'b1;
        fifo_count = {8'd0, 8'd0, 8'd3, 8'd0};
        for (int i = 0; i < NUM_SRC; i++) begin
            fifo_dout[i*DATA_W +: DATA_W] = pat(i);
        end

        // Reset values with host_req held high
        repeat (3) @(negedge clk);
        chk("rst_rd_en", fifo_rd_en, '0);
        chk("rst_host_data", host_data, '0);
        chk("rst_host_src", host_src, '0);
        chk("rst_host_valid", host_valid, 1'b0);
        chk("rst_host_empty", host_empty, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_total", total_count, '0);

        // Release with host_req already high: not a request
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("rel_host_valid", host_valid, 1'b0);
        chk("rel_host_empty", host_empty, 1'b1);
        chk("rel_busy", busy, 1'b0);
        chk("rel_total", total_count, 32'd3);
        host_req = 1'b0;
        @(negedge clk);

        // Single request to FIFO 1
        issue(4'b0010, 1);
        wait_drain();

        // Fresh pointer, all FIFOs populated: 0,1,2,3 in order
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        fifo_count = {8'd2, 8'd2, 8'd2, 8'd2};
        @(negedge clk);
        for (int s = 0; s < NUM_SRC; s++) begin
            issue(NUM_SRC'(1) << s, s);
            wait_drain();
        end

        // Skip empty FIFOs and wrap: pointer 0 -> 0, then 3, then 0
        fifo_count = {8'd1, 8'd0, 8'd0, 8'd1};
        @(negedge clk);
        issue(4'b0001, 0);
        wait_drain();
        issue(4'b1000, 3);
        wait_drain();
        issue(4'b0001, 0);
        wait_drain();

        // All empty: zero response, pointer stays at 1
        fifo_count = '0;
        @(negedge clk);
        issue('0, 0);
        repeat (3) @(negedge clk);
        chk("empty_host_data", host_data, '0);
        chk("empty_host_empty", host_empty, 1'b1);
        chk("empty_host_valid", host_valid, 1'b0);
        chk("empty_busy", busy, 1'b0);
        fifo_count = {8'd1, 8'd1, 8'd1, 8'd1};
        @(negedge clk);
        issue(4'b0010, 1);
        wait_drain();

        // Second edge while busy is ignored
        begin
            rd_t  e;
            res_t r;
            host_req = 1'b1;
            e.en  = 4'b0100; e.cyc = cyc + 2;
            r.data = pat(2); r.src = 2'd2; r.cyc = cyc + 4 + RD_LAT;
            rd_q.push_back(e);
            res_q.push_back(r);
            repeat (2) @(negedge clk);
            host_req = 1'b0;
            @(negedge clk);
            chk("busy_during_wait", busy, 1'b1);
            host_req = 1'b1;
            @(negedge clk);
            host_req = 1'b0;
            wait_drain();
            repeat (8) @(negedge clk);
        end

        // Occupancy at full counts, then reset in the middle of a pop
        fifo_count = {8'd255, 8'd255, 8'd255, 8'd255};
        @(negedge clk);
        chk("total_full", total_count, 32'd1020);
        begin
            rd_t e;
            host_req = 1'b1;
            e.en = 4'b1000; e.cyc = cyc + 2;
            rd_q.push_back(e);
            @(negedge clk);
            host_req = 1'b0;
            @(negedge clk);
            #2;
            chk("pop_before_reset", fifo_rd_en, 4'b1000);
            reset = 1'b0;
            #1;
            chk("mid_rst_rd_en", fifo_rd_en, '0);
            chk("mid_rst_host_data", host_data, '0);
            chk("mid_rst_host_src", host_src, '0);
            chk("mid_rst_host_valid", host_valid, 1'b0);
            chk("mid_rst_host_empty", host_empty, 1'b1);
            chk("mid_rst_busy", busy, 1'b0);
            chk("mid_rst_total", total_count, '0);
            res_q.delete();
            rd_q.delete();
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
        end

        // Recovery after reset: pointer back at 0
        issue(4'b0001, 0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pair_exit_arbiter.md
Name: pair_exit_arbiter

Overview:
Shares one host read channel among NUM_SRC pair-exit FIFOs, one per force pipeline, to drain computed particle pairs. On each host read request it picks the next non-empty FIFO round-robin, pops one entry, and presents it with its source index. When every FIFO is empty it returns a zero word flagged empty. It also reports the aggregate occupancy of all FIFOs. It sits between the per-pipeline exit FIFOs and the host register/DMA interface.

Parameters:
NUM_SRC, 4, number of exit FIFOs arbitrated (2..16)
SRC_W, 2, width of source index, equals ceil(log2(NUM_SRC))
DATA_W, 192, width of one FIFO entry (a particle pair)
CNT_W, 8, width of each FIFO data_count
RD_LAT, 1, cycles from a FIFO rd_en to valid dout (1..3)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
fifo_count  input  NUM_SRC*CNT_W  occupancy of FIFO i in bits [i*CNT_W +: CNT_W]
fifo_dout  input  NUM_SRC*DATA_W  read data of FIFO i in bits [i*DATA_W +: DATA_W]
fifo_rd_en  output  NUM_SRC  one-hot pop strobe to FIFO i
host_req  input  1  level from host; each 0->1 transition is one read request
host_data  output  DATA_W  last popped entry, or zero on an empty response
host_src  output  SRC_W  index of the FIFO host_data came from
host_valid  output  1  host_data holds a fresh entry
host_empty  output  1  last request found all FIFOs empty
busy  output  1  high while a request is being serviced (state != IDLE)
total_count  output  32  registered sum of all fifo_count fields, zero-extended

Behaviour:
- Reset (reset=0, asynchronous) values:
  - fifo_rd_en=0, host_data=0, host_src=0, host_valid=0, host_empty=1, busy=0, total_count=0.
  - Internal: state=IDLE, rr_ptr=0, req_pend=0, prev_req=1. prev_req=1 means a host_req already high at reset release is not a request.
  - A reset during POP or WAIT drops fifo_rd_en immediately. An entry already popped is lost; this is accepted.
- Request detection: edge = host_req & ~prev_req. prev_req <= host_req every cycle. An edge in IDLE sets req_pend. Edges while busy=1 are ignored.
- FSM states: IDLE, POP, WAIT, PRESENT.
  - IDLE, req_pend=1, some fifo_count[i]!=0:
    - grant = first i with nonzero count, searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
    - Next state POP. host_valid <= 0.
  - IDLE, req_pend=1, all counts zero:
    - host_data <= 0, host_valid <= 0, host_empty <= 1, req_pend <= 0.
    - Stay IDLE. rr_ptr is unchanged.
  - POP: fifo_rd_en[grant]=1 for exactly this one cycle, all other bits 0. Next state WAIT with lat_cnt=RD_LAT-1.
  - WAIT: if lat_cnt==0 go to PRESENT, else decrement lat_cnt. fifo_rd_en=0.
  - PRESENT: one cycle.
    - host_data <= fifo_dout[grant], host_src <= grant, host_valid <= 1, host_empty <= 0, req_pend <= 0.
    - rr_ptr <= (grant==NUM_SRC-1) ? 0 : grant+1.
    - Next state IDLE.
- Latency: from the edge cycle to host_valid=1 is 3+RD_LAT cycles (4 when RD_LAT=1). The sequence is edge, IDLE-evaluate, POP, RD_LAT cycles, PRESENT-register.
- host_data, host_src, host_valid and host_empty hold their values until the next request resolves.
- fifo_count is sampled only in IDLE. It is never decremented locally; the FIFO updates its own count after the pop.
- A single fifo_count may go from 0 to nonzero in the same cycle as the search. Whatever is sampled that cycle decides the result.
- Never pulse rd_en to a FIFO whose sampled count was 0. At most one rd_en bit is high in any cycle.
- total_count: registered every cycle with no wrap. The maximum sum NUM_SRC*(2^CNT_W-1) fits in 32 bits.
- busy = (state != IDLE), registered.

Test Plan:
- Reset with host_req=1, then release with counts {0,3,0,0} -> no rd_en pulse, host_empty=1, host_valid=0.
- Counts {0,3,0,0}, fifo_dout[1]=192'hA5..A5, one host_req edge -> fifo_rd_en=4'b0010 for exactly 1 cycle; 4 cycles after the edge host_valid=1, host_src=1, host_data=A5..A5.
- Counts {2,2,2,2}, four spaced requests -> host_src sequence 0,1,2,3; rd_en one-hot each time.
- All counts 0, request -> host_data=0, host_empty=1, host_valid=0, no rd_en pulse, rr_ptr unchanged (the next request with counts {1,1,1,1} returns src 0).
- Second host_req edge while busy=1 -> ignored: only one rd_en pulse, one result.
- Counts {255,255,255,255} -> total_count=1020 one cycle later; assert reset during POP -> rd_en=0 at once and all outputs at reset values.
